// File: rtl/lcd_bus_pkg.sv
// Shared opcodes, fill character and state types for the LCD bus receiver.
package lcd_bus_pkg;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_ENTRY = 8'h04;
    localparam logic [7:0] CMD_CGRAM = 8'h40;
    localparam logic [7:0] CMD_DDRAM = 8'h80;
    localparam logic [3:0] FUNC4     = 4'h2;
    localparam logic [7:0] SPACE     = 8'h20;

    typedef enum logic [1:0] {
        NIB_IF8,
        NIB_IF4_HI,
        NIB_IF4_LO
    } nib_state_t;

    typedef enum logic {
        ST_SWEEP,
        ST_IDLE
    } sweep_state_t;

endpackage

// File: rtl/lcd_bus_if.sv
// HD44780-style 4-bit LCD bus as driven by the LCD driver.
interface lcd_bus_if;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_e;
    logic [11:8] sf_d;

    modport master (output lcd_rs, lcd_rw, lcd_e, sf_d);
    modport slave  (input  lcd_rs, lcd_rw, lcd_e, sf_d);
endinterface

// File: rtl/lcd_shadow_ram.sv
// 128x8 DDRAM mirror: synchronous write, registered read (old data on collision).
module lcd_shadow_ram (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] mem [128];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= mem[raddr];
    end
endmodule

// File: rtl/lcd_bus_decoder.sv
// Passive LCD bus receiver: rebuilds bytes from E strobes, tracks the address
// counter and mirrors DDRAM writes into the shadow RAM.
//   state      | meaning
//   NIB_IF8    | 8-bit bus, every strobe is a whole byte {D,0}
//   NIB_IF4_HI | 4-bit bus, waiting for high nibble
//   NIB_IF4_LO | 4-bit bus, waiting for low nibble
//   ST_SWEEP   | clear sweep writing SPACE to every address, busy=1
//   ST_IDLE    | bytes are decoded
module lcd_bus_decoder
    import lcd_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    lcd_bus_if.slave   bus,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] ac,
    output logic       if4,
    output logic       busy,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       wr_valid,
    output logic       err
);
    logic [6:0]   sync1, sync2;
    logic         e_prev, rs_s, rw_s, e_s, strobe;
    logic [3:0]   d_s;
    nib_state_t   nib_q, nib_d;
    sweep_state_t sweep_q, sweep_d;
    logic [3:0]   hi_q, hi_d;
    logic         hi_rs_q, hi_rs_d;
    logic [6:0]   saddr_q, saddr_d, ac_d;
    logic         id_inc_q, id_inc_d, cgram_q, cgram_d;
    logic [7:0]   cmd_byte_d, byte_val;
    logic         cmd_valid_d, wr_valid_d, err_d;
    logic         byte_done, byte_rs, rs_err, start_sweep, data_we;

    assign {rs_s, rw_s, e_s, d_s} = sync2;
    assign strobe = e_prev & ~e_s & ~rw_s;
    assign busy   = (sweep_q == ST_SWEEP);
    assign if4    = (nib_q != NIB_IF8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            e_prev    <= 1'b0;
            nib_q     <= NIB_IF8;
            sweep_q   <= ST_SWEEP;
            hi_q      <= '0;
            hi_rs_q   <= 1'b0;
            saddr_q   <= '0;
            id_inc_q  <= 1'b1;
            cgram_q   <= 1'b0;
            ac        <= '0;
            cmd_byte  <= '0;
            cmd_valid <= 1'b0;
            wr_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            sync1     <= {bus.lcd_rs, bus.lcd_rw, bus.lcd_e, bus.sf_d};
            sync2     <= sync1;
            e_prev    <= e_s;
            nib_q     <= nib_d;
            sweep_q   <= sweep_d;
            hi_q      <= hi_d;
            hi_rs_q   <= hi_rs_d;
            saddr_q   <= saddr_d;
            id_inc_q  <= id_inc_d;
            cgram_q   <= cgram_d;
            ac        <= ac_d;
            cmd_byte  <= cmd_byte_d;
            cmd_valid <= cmd_valid_d;
            wr_valid  <= wr_valid_d;
            err       <= err_d;
        end
    end

    // Nibble assembly; the IF8->IF4 switch only honours function-set when not busy
    always_comb begin
        nib_d     = nib_q;
        hi_d      = hi_q;
        hi_rs_d   = hi_rs_q;
        byte_done = 1'b0;
        byte_val  = '0;
        byte_rs   = 1'b0;
        rs_err    = 1'b0;
        if (strobe) begin
            unique case (nib_q)
                NIB_IF8: begin
                    byte_done = 1'b1;
                    byte_val  = {d_s, 4'h0};
                    byte_rs   = rs_s;
                    if (!busy && !rs_s && d_s == FUNC4) nib_d = NIB_IF4_HI;
                end
                NIB_IF4_HI: begin
                    hi_d    = d_s;
                    hi_rs_d = rs_s;
                    nib_d   = NIB_IF4_LO;
                end
                NIB_IF4_LO: begin
                    nib_d = NIB_IF4_HI;
                    if (rs_s != hi_rs_q) begin
                        rs_err = 1'b1;
                    end else begin
                        byte_done = 1'b1;
                        byte_val  = {hi_q, d_s};
                        byte_rs   = rs_s;
                    end
                end
                default: nib_d = NIB_IF8;
            endcase
        end
    end

    always_comb begin
        ac_d        = ac;
        id_inc_d    = id_inc_q;
        cgram_d     = cgram_q;
        cmd_byte_d  = cmd_byte;
        cmd_valid_d = 1'b0;
        wr_valid_d  = 1'b0;
        err_d       = rs_err | (byte_done & busy);
        start_sweep = 1'b0;
        data_we     = 1'b0;
        if (byte_done && !busy) begin
            if (!byte_rs) begin
                cmd_valid_d = 1'b1;
                cmd_byte_d  = byte_val;
                if (byte_val[7] == CMD_DDRAM[7]) begin
                    ac_d    = byte_val[6:0];
                    cgram_d = 1'b0;
                end else if (byte_val[7:6] == CMD_CGRAM[7:6]) begin
                    cgram_d = 1'b1;
                end else if (byte_val[7:2] == CMD_ENTRY[7:2]) begin
                    id_inc_d = byte_val[1];
                end else if (byte_val[7:1] == CMD_HOME[7:1]) begin
                    ac_d    = '0;
                    cgram_d = 1'b0;
                end else if (byte_val == CMD_CLEAR) begin
                    start_sweep = 1'b1;
                    ac_d        = '0;
                    id_inc_d    = 1'b1;
                    cgram_d     = 1'b0;
                end
            end else if (!cgram_q) begin
                wr_valid_d = 1'b1;
                data_we    = 1'b1;
                ac_d       = id_inc_q ? ac + 7'd1 : ac - 7'd1;
            end
        end
    end

    always_comb begin
        sweep_d = sweep_q;
        saddr_d = saddr_q;
        if (sweep_q == ST_SWEEP) begin
            saddr_d = saddr_q + 7'd1;
            if (saddr_q == 7'h7F) sweep_d = ST_IDLE;
        end
        if (start_sweep) begin
            sweep_d = ST_SWEEP;
            saddr_d = '0;
        end
    end

    lcd_shadow_ram u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (busy | data_we),
        .waddr (busy ? saddr_q : ac),
        .wdata (busy ? SPACE : byte_val),
        .raddr (rd_addr),
        .rdata (rd_char)
    );
endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Bench for lcd_bus_decoder: drives LCD bus strobes and compares against a
// byte-level model of the display controller.
module tb_lcd_bus_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] rd_addr = '0;
    logic [7:0] rd_char, cmd_byte;
    logic [6:0] ac;
    logic       if4, busy, cmd_valid, wr_valid, err;

    lcd_bus_if bus ();

    lcd_bus_decoder dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .rd_addr(rd_addr), .rd_char(rd_char),
        .ac(ac), .if4(if4), .busy(busy), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
        .wr_valid(wr_valid), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cmd_cnt = 0, wr_cnt = 0, err_cnt = 0, busy_cnt = 0;
    logic [7:0] last_cmd = '0;
    bit quiet = 0;

    bit         m_if4, m_hi_phase, m_hi_rs, m_inc, m_cg;
    logic [3:0] m_hi;
    int         m_ac;
    logic [7:0] m_cmd;
    logic [7:0] m_ram [128];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller behaviour for one E strobe; returns the pulses it must cause.
    task automatic model_strobe(input bit rs, input bit rw, input logic [3:0] d, input bit in_busy,
                                output int e_cmd, output int e_wr, output int e_err);
        logic [7:0] b;
        bit brs, done;
        e_cmd = 0; e_wr = 0; e_err = 0; done = 0; b = '0; brs = 0;
        if (rw) return;
        if (!m_if4) begin
            b = {d, 4'h0}; brs = rs; done = 1;
        end else if (m_hi_phase) begin
            m_hi = d; m_hi_rs = rs; m_hi_phase = 0;
        end else begin
            m_hi_phase = 1;
            if (rs != m_hi_rs) e_err = 1;
            else begin b = {m_hi, d}; brs = rs; done = 1; end
        end
        if (!done) return;
        if (in_busy) begin
            e_err = 1;
        end else if (!brs) begin
            e_cmd = 1;
            m_cmd = b;
            if (!m_if4 && d == 4'h2) begin m_if4 = 1; m_hi_phase = 1; end
            if (b >= 8'h80) begin m_ac = int'(b) - 128; m_cg = 0; end
            else if (b >= 8'h40) m_cg = 1;
            else if (b >= 8'h04 && b <= 8'h07) m_inc = b[1];
            else if (b == 8'h02 || b == 8'h03) begin m_ac = 0; m_cg = 0; end
            else if (b == 8'h01) begin
                m_ac = 0; m_inc = 1; m_cg = 0;
                for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
            end
        end else if (!m_cg) begin
            e_wr = 1;
            m_ram[m_ac] = b;
            m_ac = (m_ac + (m_inc ? 1 : 127)) % 128;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (cmd_valid) begin cmd_cnt++; last_cmd = cmd_byte; end
            if (wr_valid) wr_cnt++;
            if (err) err_cnt++;
            if (busy) busy_cnt++;
            if (quiet) begin
                chk("ac", ac, m_ac);
                chk("if4", if4, m_if4);
                chk("cmd_byte", cmd_byte, m_cmd);
            end
        end
    end

    task automatic nib(input bit rs, input bit rw, input logic [3:0] d, input bit in_busy);
        int c0, w0, x0, ec, ew, ee;
        c0 = cmd_cnt; w0 = wr_cnt; x0 = err_cnt;
        quiet = 0;
        @(negedge clk);
        bus.lcd_rs = rs; bus.lcd_rw = rw; bus.sf_d = d; bus.lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (6) @(negedge clk);
        model_strobe(rs, rw, d, in_busy, ec, ew, ee);
        chk("cmd_pulses", cmd_cnt - c0, ec);
        chk("wr_pulses", wr_cnt - w0, ew);
        chk("err_pulses", err_cnt - x0, ee);
        if (ec != 0) chk("cmd_pulse_byte", last_cmd, m_cmd);
        quiet = 1;
    endtask

    task automatic send_byte(input bit rs, input logic [7:0] b, input bit in_busy);
        nib(rs, 1'b0, b[7:4], in_busy);
        nib(rs, 1'b0, b[3:0], in_busy);
    endtask

    task automatic read_chk(input logic [6:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        chk(name, rd_char, exp);
    endtask

    task automatic wait_idle(input int b0, input string name);
        int n = 0;
        while (busy && n < 400) begin @(negedge clk); n++; end
        chk("busy_timeout", busy, 0);
        chk(name, busy_cnt - b0, 128);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, r;
        logic [7:0] v;
        bit rsh;
        bus.lcd_rs = 0; bus.lcd_rw = 0; bus.lcd_e = 0; bus.sf_d = '0;
        m_if4 = 0; m_hi_phase = 1; m_hi_rs = 0; m_inc = 1; m_cg = 0; m_hi = '0;
        m_ac = 0; m_cmd = 8'h00;
        for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;

        repeat (3) @(negedge clk);
        chk("rst_ac", ac, 0);
        chk("rst_if4", if4, 0);
        chk("rst_busy", busy, 1);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_byte", cmd_byte, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_char", rd_char, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        b0 = busy_cnt;
        quiet = 1;
        wait_idle(b0, "busy_cycles_after_reset");
        read_chk(7'h05, 8'h20, "ram05_after_reset");
        read_chk(7'h7F, 8'h20, "ram7f_after_reset");

        nib(0, 0, 4'h3, 0); nib(0, 0, 4'h3, 0); nib(0, 0, 4'h3, 0); nib(0, 0, 4'h2, 0);
        chk("if4_after_init", if4, 1);

        send_byte(0, 8'h80, 0); send_byte(1, 8'h54, 0); send_byte(1, 8'h69, 0);
        chk("ac_after_two_writes", ac, 2);
        read_chk(7'h00, 8'h54, "ram00");
        read_chk(7'h01, 8'h69, "ram01");

        send_byte(0, 8'hC0, 0); send_byte(1, 8'h50, 0);
        chk("ac_after_c0_write", ac, 7'h41);
        read_chk(7'h40, 8'h50, "ram40");
        send_byte(0, 8'h40, 0); send_byte(1, 8'h11, 0);
        read_chk(7'h41, 8'h20, "ram41_cgram_untouched");

        nib(1, 0, 4'h5, 0); nib(0, 0, 4'h3, 0);
        send_byte(0, 8'h90, 0);
        nib(1, 0, 4'h3, 0); nib(0, 1, 4'hF, 0); nib(1, 0, 4'h3, 0);
        read_chk(7'h10, 8'h33, "ram10_after_rs_error");
        chk("ac_after_rs_error", ac, 7'h11);

        send_byte(0, 8'h04, 0); send_byte(0, 8'h80, 0); send_byte(1, 8'h7A, 0);
        chk("ac_wrap_down", ac, 7'h7F);
        read_chk(7'h00, 8'h7A, "ram00_decrement");
        send_byte(0, 8'h06, 0);

        send_byte(0, 8'hFF, 0); send_byte(1, 8'h41, 0);
        chk("ac_wrap_up", ac, 0);
        read_chk(7'h7F, 8'h41, "ram7f");

        b0 = busy_cnt;
        send_byte(0, 8'h01, 0);
        chk("busy_after_clear", busy, 1);
        send_byte(1, 8'h77, 1);
        wait_idle(b0, "busy_cycles_after_clear");
        for (int i = 0; i < 128; i++) read_chk(7'(i), m_ram[i], "ram_after_clear");

        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            v = 8'($urandom);
            case (r)
                0, 1, 2, 3: send_byte(1, v, 0);
                4: send_byte(0, {1'b1, v[6:0]}, 0);
                5: send_byte(0, {2'b01, v[5:0]}, 0);
                6: send_byte(0, {6'b000001, v[1:0]}, 0);
                7: send_byte(0, {7'b0000001, v[0]}, 0);
                8: begin
                    rsh = v[0];
                    nib(rsh, 0, v[7:4], 0);
                    nib(!rsh, 0, v[3:0], 0);
                end
                default: begin
                    nib(0, 1, v[3:0], 0);
                    send_byte(0, 8'($urandom_range(8, 63)), 0);
                end
            endcase
        end
        for (int i = 0; i < 128; i++) read_chk(7'(i), m_ram[i], "ram_after_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
